// File: rtl/traffic_phase_sequencer.sv
// Traffic-light phase sequencer: GREEN -> YELLOW -> RED cycle with a sticky
// pedestrian request that lengthens the next RED, plus a fault override.
module traffic_phase_sequencer #(
    parameter int unsigned T_GREEN   = 10,
    parameter int unsigned T_YELLOW  = 2,
    parameter int unsigned T_RED     = 8,
    parameter int unsigned T_PED_EXT = 4,
    parameter int unsigned CNT_W     = 5
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic             run,
    input  logic             ped_req,
    input  logic             fault,
    output logic [1:0]       cur_state,
    output logic             en,
    output logic             ped_ack,
    output logic [CNT_W-1:0] remaining
);

    typedef enum logic [1:0] {
        ST_GREEN  = 2'b00,
        ST_YELLOW = 2'b01,
        ST_RED    = 2'b10,
        ST_FAULT  = 2'b11
    } state_e;

    localparam logic [CNT_W-1:0] LD_GREEN   = CNT_W'(T_GREEN - 1);
    localparam logic [CNT_W-1:0] LD_YELLOW  = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] LD_RED     = CNT_W'(T_RED - 1);
    localparam logic [CNT_W-1:0] LD_RED_EXT = CNT_W'(T_RED + T_PED_EXT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             ped_pend_q, ped_pend_d;
    logic             en_q, en_d;
    logic             ack_q, ack_d;
    logic             pend_set_s;

    // State, timer and output registers
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q    <= ST_GREEN;
            timer_q    <= LD_GREEN;
            ped_pend_q <= 1'b0;
            en_q       <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            ped_pend_q <= ped_pend_d;
            en_q       <= en_d;
            ack_q      <= ack_d;
        end
    end

    // Next-state, timer reload and pedestrian bookkeeping
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        ped_pend_d = ped_pend_q;
        ack_d      = 1'b0;
        en_d       = run | fault;
        // A request arriving on the YELLOW->RED edge still counts for that RED.
        pend_set_s = ped_pend_q | ped_req;

        if (fault) begin
            state_d    = ST_FAULT;
            timer_d    = CNT_ZERO;
            ped_pend_d = 1'b0;
        end else if (state_q == ST_FAULT) begin
            state_d    = ST_RED;
            timer_d    = LD_RED;
            ped_pend_d = 1'b0;
        end else begin
            ped_pend_d = pend_set_s;
            if (run) begin
                if (timer_q != CNT_ZERO) begin
                    timer_d = timer_q - CNT_ONE;
                end else begin
                    case (state_q)
                        ST_GREEN: begin
                            state_d = ST_YELLOW;
                            timer_d = LD_YELLOW;
                        end
                        ST_YELLOW: begin
                            state_d = ST_RED;
                            if (pend_set_s) begin
                                timer_d    = LD_RED_EXT;
                                ack_d      = 1'b1;
                                ped_pend_d = 1'b0;
                            end else begin
                                timer_d = LD_RED;
                            end
                        end
                        ST_RED: begin
                            state_d = ST_GREEN;
                            timer_d = LD_GREEN;
                        end
                        default: begin
                            state_d = ST_FAULT;
                            timer_d = CNT_ZERO;
                        end
                    endcase
                end
            end else begin
                timer_d = timer_q;
            end
        end
    end

    assign cur_state = state_q;
    assign remaining = timer_q;
    assign en        = en_q;
    assign ped_ack   = ack_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed bench for traffic_phase_sequencer: a vector table for run/hold,
// pedestrian and fault steps, plus hand sequences for whole-cycle timing.
module tb_traffic_phase_sequencer;

    logic       clk = 1'b0;
    logic       res_n = 1'b0;
    logic       run = 1'b0;
    logic       ped_req = 1'b0;
    logic       fault = 1'b0;
    logic [1:0] cur_state;
    logic       en;
    logic       ped_ack;
    logic [4:0] remaining;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic run;
        logic ped;
        logic flt;
        int   st;
        int   rem;
        int   en;
        int   ack;
    } vec_t;

    vec_t tbl[22];

    traffic_phase_sequencer dut (
        .clk       (clk),
        .res_n     (res_n),
        .run       (run),
        .ped_req   (ped_req),
        .fault     (fault),
        .cur_state (cur_state),
        .en        (en),
        .ped_ack   (ped_ack),
        .remaining (remaining)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_reset();
        res_n   = 1'b0;
        run     = 1'b0;
        ped_req = 1'b0;
        fault   = 1'b0;
        tick();
        tick();
    endtask

    task automatic release_reset(input logic r);
        res_n = 1'b1;
        run   = r;
    endtask

    // Index 0 is the first cycle after reset release; run held 1 throughout.
    task automatic seq_check(input string name, input int n, input int ped_a,
                             input int ped_b, input int red1, input int red2);
        int len[7];
        len = '{10, 2, red1, 10, 2, red2, 10};
        for (int i = 0; i < n; i++) begin
            int seg;
            int off;
            int exp_st;
            seg = 0;
            off = i;
            while (seg < 6 && off >= len[seg]) begin
                off = off - len[seg];
                seg++;
            end
            exp_st = (seg % 3 == 0) ? 0 : ((seg % 3 == 1) ? 1 : 2);
            chk($sformatf("%s state@%0d", name, i), int'(cur_state), exp_st);
            chk($sformatf("%s rem@%0d", name, i), int'(remaining), len[seg] - 1 - off);
            chk($sformatf("%s en@%0d", name, i), int'(en), (i == 0) ? 0 : 1);
            chk($sformatf("%s ack@%0d", name, i), int'(ped_ack),
                (seg % 3 == 2 && off == 0 && len[seg] == 12) ? 1 : 0);
            ped_req = (i == ped_a || i == ped_b);
            tick();
        end
        ped_req = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 0, 8, 1, 0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 0, 7, 1, 0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 0, 6, 1, 0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 0, 5, 1, 0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 0, 4, 1, 0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 0, 4, 0, 0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 0, 4, 0, 0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 0, 4, 0, 0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 0, 4, 0, 0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 0, 4, 0, 0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 0, 3, 1, 0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 0, 2, 1, 0};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 0, 1, 1, 0};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 0, 0, 1, 0};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 1, 1, 1, 0};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 1, 0, 1, 0};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 2, 11, 1, 1};
        tbl[17] = '{1'b1, 1'b0, 1'b0, 2, 10, 1, 0};
        tbl[18] = '{1'b0, 1'b0, 1'b1, 3, 0, 1, 0};
        tbl[19] = '{1'b0, 1'b0, 1'b0, 2, 7, 0, 0};
        tbl[20] = '{1'b0, 1'b0, 1'b0, 2, 7, 0, 0};
        tbl[21] = '{1'b1, 1'b0, 1'b0, 2, 6, 1, 0};

        // Reset values while reset is held
        hold_reset();
        chk("reset state", int'(cur_state), 0);
        chk("reset rem", int'(remaining), 9);
        chk("reset en", int'(en), 0);
        chk("reset ack", int'(ped_ack), 0);

        // Vector table: freeze, sticky request under run=0, fault restart
        release_reset(1'b0);
        for (int v = 0; v < 22; v++) begin
            run     = tbl[v].run;
            ped_req = tbl[v].ped;
            fault   = tbl[v].flt;
            tick();
            chk($sformatf("vec%0d state", v), int'(cur_state), tbl[v].st);
            chk($sformatf("vec%0d rem", v), int'(remaining), tbl[v].rem);
            chk($sformatf("vec%0d en", v), int'(en), tbl[v].en);
            chk($sformatf("vec%0d ack", v), int'(ped_ack), tbl[v].ack);
        end
        ped_req = 1'b0;
        fault   = 1'b0;

        // Two plain cycles
        hold_reset();
        release_reset(1'b1);
        seq_check("plain", 40, -1, -1, 8, 8);

        // Request in GREEN cycle 3
        hold_reset();
        release_reset(1'b1);
        seq_check("ped_g3", 46, 2, -1, 12, 8);

        // Request on the YELLOW->RED edge, then again during the long RED
        hold_reset();
        release_reset(1'b1);
        seq_check("ped_edge", 50, 11, 15, 12, 12);

        // Fault in YELLOW cycle 1, held 6 cycles
        hold_reset();
        release_reset(1'b1);
        repeat (10) tick();
        chk("flt pre state", int'(cur_state), 1);
        chk("flt pre rem", int'(remaining), 1);
        fault = 1'b1;
        tick();
        chk("flt state", int'(cur_state), 3);
        chk("flt rem", int'(remaining), 0);
        chk("flt en", int'(en), 1);
        run     = 1'b0;
        ped_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("flt hold%0d state", k), int'(cur_state), 3);
            chk($sformatf("flt hold%0d rem", k), int'(remaining), 0);
            chk($sformatf("flt hold%0d en", k), int'(en), 1);
        end
        fault   = 1'b0;
        ped_req = 1'b0;
        run     = 1'b1;
        tick();
        chk("flt exit state", int'(cur_state), 2);
        chk("flt exit rem", int'(remaining), 7);
        chk("flt exit ack", int'(ped_ack), 0);
        for (int k = 1; k < 8; k++) begin
            tick();
            chk($sformatf("flt red%0d state", k), int'(cur_state), 2);
            chk($sformatf("flt red%0d rem", k), int'(remaining), 7 - k);
        end
        tick();
        chk("flt green state", int'(cur_state), 0);
        chk("flt green rem", int'(remaining), 9);
        repeat (12) tick();
        chk("flt next red state", int'(cur_state), 2);
        chk("flt next red rem", int'(remaining), 7);
        chk("flt next red ack", int'(ped_ack), 0);

        // Reset mid-RED with a request pending
        hold_reset();
        release_reset(1'b1);
        for (int i = 0; i < 16; i++) begin
            ped_req = (i == 2 || i == 14);
            tick();
        end
        ped_req = 1'b0;
        chk("mid red state", int'(cur_state), 2);
        #2;
        res_n = 1'b0;
        #1;
        chk("async rst state", int'(cur_state), 0);
        chk("async rst rem", int'(remaining), 9);
        chk("async rst en", int'(en), 0);
        chk("async rst ack", int'(ped_ack), 0);
        @(posedge clk);
        #1;
        release_reset(1'b1);
        seq_check("post_rst", 22, -1, -1, 8, 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
